// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit_if
//  Description : EX-stage multiply/divide bundle. It carries the issue-side
//                controls and operands toward md_unit, and Busy/HI/LO back.
//                master : pipeline side (drives controls, reads status)
//                slave  : md_unit side (reads controls, drives status)
//  Signals     : EXC_flush   1  flush of the EX-stage instruction
//                Start_E     1  valid multiply/divide-class instruction
//                MDControl_E 3  operation select
//                RS_E/RT_E   32 forwarded operands
//                Busy        1  multi-cycle operation in flight
//                HI/LO       32 architectural HI/LO registers
//  Revision    : 1.0  initial release
// ============================================================================
interface md_unit_if;
  logic        EXC_flush;
  logic        Start_E;
  logic [2:0]  MDControl_E;
  logic [31:0] RS_E;
  logic [31:0] RT_E;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output EXC_flush, Start_E, MDControl_E, RS_E, RT_E,
    input  Busy, HI, LO
  );

  modport slave (
    input  EXC_flush, Start_E, MDControl_E, RS_E, RT_E,
    output Busy, HI, LO
  );
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit
//  Description : Multi-cycle multiply/divide unit holding HI/LO. Multiplies
//                and divides keep Busy high for MULT_CYCLES / DIV_CYCLES
//                cycles and write HI/LO on the edge where Busy falls.
//                mthi/mtlo write in a single edge without raising Busy.
//  Ports       : clk    clock, rising edge
//                reset  asynchronous, active-low reset
//                md     md_unit_if.slave (controls, operands, Busy, HI, LO)
//  Revision    : 1.0  initial release
// ============================================================================
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  md
);

  localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

  localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  localparam logic [2:0] c_OP_MULT  = 3'b000;
  localparam logic [2:0] c_OP_MULTU = 3'b001;
  localparam logic [2:0] c_OP_DIV   = 3'b010;
  localparam logic [2:0] c_OP_DIVU  = 3'b011;
  localparam logic [2:0] c_OP_MTHI  = 3'b100;
  localparam logic [2:0] c_OP_MTLO  = 3'b101;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [1:0]          r_op;          // low bits of mult/multu/div/divu opcode
  logic [31:0]         r_rs, r_rt;
  logic [31:0]         r_hi, w_hi_nxt;
  logic [31:0]         r_lo, w_lo_nxt;
  logic                w_latch;
  logic                w_accept;

  // ---------------------------------------------------------------------------
  // Result datapath, fed only by the latched operands so that forwarding
  // changes on RS_E/RT_E during the busy period cannot corrupt the result.
  // r_op[0]=1 selects unsigned, r_op[1]=1 selects divide.
  // ---------------------------------------------------------------------------
  logic        w_signed;
  logic [63:0] w_a_ext, w_b_ext, w_prod;
  logic        w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag, w_quo_mag, w_rem_mag, w_quo, w_rem;
  logic        w_div_zero;

  assign w_signed = ~r_op[0];
  assign w_a_neg  = w_signed & r_rs[31];
  assign w_b_neg  = w_signed & r_rt[31];

  // Sign/zero extension to 64 bits makes the truncated product correct for
  // both the signed and the unsigned case.
  assign w_a_ext = {{32{w_a_neg}}, r_rs};
  assign w_b_ext = {{32{w_b_neg}}, r_rt};
  assign w_prod  = w_a_ext * w_b_ext;

  // Divide on magnitudes, then restore signs: quotient truncates toward zero
  // and the remainder follows the dividend. 0x80000000 / -1 falls out of this
  // naturally as 0x80000000 remainder 0, without signed-overflow behaviour.
  assign w_a_mag    = w_a_neg ? (~r_rs + 32'd1) : r_rs;
  assign w_b_mag    = w_b_neg ? (~r_rt + 32'd1) : r_rt;
  assign w_div_zero = (r_rt == 32'd0);
  assign w_quo_mag  = w_div_zero ? 32'd0 : (w_a_mag / w_b_mag);
  assign w_rem_mag  = w_div_zero ? 32'd0 : (w_a_mag % w_b_mag);
  assign w_quo      = (w_a_neg ^ w_b_neg) ? (~w_quo_mag + 32'd1) : w_quo_mag;
  assign w_rem      = w_a_neg ? (~w_rem_mag + 32'd1) : w_rem_mag;

  // ---------------------------------------------------------------------------
  // Control: Busy is the registered running flag, so accept needs idle.
  // ---------------------------------------------------------------------------
  assign w_accept = md.Start_E & ~md.EXC_flush & (r_state == S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (md.MDControl_E)
            c_OP_MULT, c_OP_MULTU: begin
              w_latch     = 1'b1;
              w_cnt_nxt   = c_MULT_LOAD;
              w_state_nxt = S_RUN;
            end
            c_OP_DIV, c_OP_DIVU: begin
              w_latch     = 1'b1;
              w_cnt_nxt   = c_DIV_LOAD;
              w_state_nxt = S_RUN;
            end
            c_OP_MTHI: w_hi_nxt = md.RS_E;
            c_OP_MTLO: w_lo_nxt = md.RS_E;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt - c_CNT_ONE;
        // Counter reaches zero on this edge: commit and leave.
        if (r_cnt <= c_CNT_ONE) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          if (!r_op[1]) begin
            w_hi_nxt = w_prod[63:32];
            w_lo_nxt = w_prod[31:0];
          end else if (!w_div_zero) begin
            w_hi_nxt = w_rem;
            w_lo_nxt = w_quo;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= 2'b00;
      r_rs    <= 32'd0;
      r_rt    <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      if (w_latch) begin
        r_op <= md.MDControl_E[1:0];
        r_rs <= md.RS_E;
        r_rt <= md.RT_E;
      end
    end
  end

  assign md.Busy = (r_state == S_RUN);
  assign md.HI   = r_hi;
  assign md.LO   = r_lo;

endmodule
`default_nettype wire
